// File: rtl/bellek_asamasi_pkg.sv
// rtl/bellek_asamasi_pkg.sv - access size codes, stage states and size helper for the memory stage
package bellek_asamasi_pkg;

  localparam logic [1:0] BOYUT_B = 2'd0;
  localparam logic [1:0] BOYUT_H = 2'd1;
  localparam logic [1:0] BOYUT_W = 2'd2;
  localparam logic [1:0] BOYUT_D = 2'd3;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } durum_e;

  function automatic logic [3:0] boyut_bayt(input logic [1:0] boyut);
    return 4'd1 << boyut;
  endfunction

endpackage

// File: rtl/bellek_asamasi_hizalayici.sv
// rtl/bellek_asamasi_hizalayici.sv - bellek_hizalayici: byte strobes, store lane shift, load lane select and extension
module bellek_hizalayici
  import bellek_asamasi_pkg::*;
#(
  parameter int VERI_BIT = 32
) (
  input  logic [1:0]                     boyut_i,
  input  logic [$clog2(VERI_BIT/8)-1:0]  ofs_i,
  input  logic                           isaretsiz_i,
  input  logic [VERI_BIT-1:0]            yaz_veri_i,
  output logic [VERI_BIT/8-1:0]          maske_o,
  output logic [VERI_BIT-1:0]            yaz_veri_o,
  input  logic [VERI_BIT-1:0]            oku_veri_i,
  output logic [VERI_BIT-1:0]            oku_veri_o
);

  localparam int BAYT = VERI_BIT / 8;

  logic [BAYT-1:0]            temel;
  logic [VERI_BIT-1:0]        kaydir;
  logic [VERI_BIT-1:0]        sola;
  logic signed [VERI_BIT-1:0] isaretli;
  int                         bos_bit;

  always_comb begin
    temel      = BAYT'((16'd1 << boyut_bayt(boyut_i)) - 16'd1);
    maske_o    = temel << ofs_i;
    yaz_veri_o = yaz_veri_i << {ofs_i, 3'b000};
    // Push the selected lane to the top, then shift back to extend from its top bit.
    kaydir     = oku_veri_i >> {ofs_i, 3'b000};
    bos_bit    = VERI_BIT - 8 * int'(boyut_bayt(boyut_i));
    sola       = kaydir << bos_bit;
    isaretli   = $signed(sola) >>> bos_bit;
    oku_veri_o = isaretsiz_i ? (sola >> bos_bit) : isaretli;
  end

endmodule

// File: rtl/bellek_asamasi.sv
// rtl/bellek_asamasi.sv - in-order core memory stage; BELLEK_HIZALAMA_DENETIMI_EN enables misalignment trapping
module bellek_asamasi
  import bellek_asamasi_pkg::*;
#(
  parameter int VERI_BIT = 32,
  parameter int PS_BIT   = 32,
  parameter int UOP_BIT  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [UOP_BIT-1:0]    uop_i,
  input  logic                  uop_gecerli_i,
  input  logic                  bel_gecerli_i,
  input  logic                  bel_yaz_i,
  input  logic [1:0]            bel_boyut_i,
  input  logic                  bel_isaretsiz_i,
  input  logic [PS_BIT-1:0]     bel_adres_i,
  input  logic [VERI_BIT-1:0]   bel_veri_i,
  output logic                  l1v_istek_gecerli_o,
  input  logic                  l1v_istek_hazir_i,
  output logic [PS_BIT-1:0]     l1v_istek_adres_o,
  output logic                  l1v_istek_yaz_o,
  output logic [VERI_BIT-1:0]   l1v_istek_veri_o,
  output logic [VERI_BIT/8-1:0] l1v_istek_maske_o,
  input  logic [VERI_BIT-1:0]   l1v_veri_i,
  input  logic                  l1v_veri_gecerli_i,
  output logic                  l1v_veri_hazir_o,
  output logic                  duraklat_o,
  output logic [UOP_BIT-1:0]    geri_yaz_uop_o,
  output logic                  geri_yaz_gecerli_o,
  output logic [VERI_BIT-1:0]   geri_yaz_veri_o,
  output logic                  hizasiz_o
);

  localparam int OFS_BIT = $clog2(VERI_BIT / 8);
  localparam logic [PS_BIT-1:0] HAT_MASKE = {{(PS_BIT-OFS_BIT){1'b1}}, {OFS_BIT{1'b0}}};

  durum_e              durum_q, durum_d;
  logic [UOP_BIT-1:0]  uop_q, uop_d, gy_uop_q, gy_uop_d;
  logic [1:0]          boyut_q, boyut_d, boyut_gir;
  logic [PS_BIT-1:0]   adres_q, adres_d, adres_gir, ofs_maske;
  logic [VERI_BIT-1:0] veri_q, veri_d, gy_veri_q, gy_veri_d;
  logic                yaz_q, yaz_d, isaretsiz_q, isaretsiz_d;
  logic                gy_gecerli_q, gy_gecerli_d, hizasiz_q, hizasiz_d;
  logic                yasal, hatali;
  logic [VERI_BIT/8-1:0] maske;
  logic [VERI_BIT-1:0] yaz_hizali, oku_genis;

  // Double accesses on a 32-bit datapath fall back to word so the lane logic stays in range.
  always_comb begin
    yasal     = (bel_boyut_i != BOYUT_D) || (VERI_BIT == 64);
    boyut_gir = yasal ? bel_boyut_i : BOYUT_W;
    ofs_maske = PS_BIT'(boyut_bayt(boyut_gir) - 4'd1);
`ifdef BELLEK_HIZALAMA_DENETIMI_EN
    hatali    = !yasal || ((bel_adres_i & ofs_maske) != '0);
    adres_gir = bel_adres_i;
`else
    hatali    = 1'b0;
    adres_gir = bel_adres_i & ~ofs_maske;
`endif
  end

  bellek_hizalayici #(.VERI_BIT(VERI_BIT)) u_hizalayici (
    .boyut_i     (boyut_q),
    .ofs_i       (adres_q[OFS_BIT-1:0]),
    .isaretsiz_i (isaretsiz_q),
    .yaz_veri_i  (veri_q),
    .maske_o     (maske),
    .yaz_veri_o  (yaz_hizali),
    .oku_veri_i  (l1v_veri_i),
    .oku_veri_o  (oku_genis)
  );

  always_comb begin
    durum_d      = durum_q;
    uop_d        = uop_q;
    boyut_d      = boyut_q;
    adres_d      = adres_q;
    veri_d       = veri_q;
    yaz_d        = yaz_q;
    isaretsiz_d  = isaretsiz_q;
    gy_uop_d     = gy_uop_q;
    gy_gecerli_d = 1'b0;
    gy_veri_d    = '0;
    hizasiz_d    = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (uop_gecerli_i) begin
          if (!bel_gecerli_i || hatali) begin
            gy_uop_d     = uop_i;
            gy_gecerli_d = 1'b1;
            hizasiz_d    = bel_gecerli_i;
          end else begin
            uop_d       = uop_i;
            boyut_d     = boyut_gir;
            adres_d     = adres_gir;
            veri_d      = bel_veri_i;
            yaz_d       = bel_yaz_i;
            isaretsiz_d = bel_isaretsiz_i;
            durum_d     = ISTEK;
          end
        end
      end
      ISTEK: begin
        if (l1v_istek_hazir_i) begin
          if (yaz_q) begin
            gy_uop_d     = uop_q;
            gy_gecerli_d = 1'b1;
            durum_d      = BOSTA;
          end else begin
            durum_d = YANIT;
          end
        end
      end
      YANIT: begin
        if (l1v_veri_gecerli_i) begin
          gy_uop_d     = uop_q;
          gy_gecerli_d = 1'b1;
          gy_veri_d    = oku_genis;
          durum_d      = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q      <= BOSTA;
      uop_q        <= '0;
      boyut_q      <= '0;
      adres_q      <= '0;
      veri_q       <= '0;
      yaz_q        <= 1'b0;
      isaretsiz_q  <= 1'b0;
      gy_uop_q     <= '0;
      gy_gecerli_q <= 1'b0;
      gy_veri_q    <= '0;
      hizasiz_q    <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      uop_q        <= uop_d;
      boyut_q      <= boyut_d;
      adres_q      <= adres_d;
      veri_q       <= veri_d;
      yaz_q        <= yaz_d;
      isaretsiz_q  <= isaretsiz_d;
      gy_uop_q     <= gy_uop_d;
      gy_gecerli_q <= gy_gecerli_d;
      gy_veri_q    <= gy_veri_d;
      hizasiz_q    <= hizasiz_d;
    end
  end

  // Request fields are driven only in ISTEK so the L1 sees zeros otherwise.
  assign l1v_istek_gecerli_o = (durum_q == ISTEK);
  assign l1v_istek_adres_o   = l1v_istek_gecerli_o ? (adres_q & HAT_MASKE) : '0;
  assign l1v_istek_yaz_o     = l1v_istek_gecerli_o & yaz_q;
  assign l1v_istek_veri_o    = (l1v_istek_gecerli_o && yaz_q) ? yaz_hizali : '0;
  assign l1v_istek_maske_o   = l1v_istek_gecerli_o ? maske : '0;
  assign l1v_veri_hazir_o    = (durum_q == YANIT);
  assign duraklat_o          = (durum_q != BOSTA);
  assign geri_yaz_uop_o      = gy_uop_q;
  assign geri_yaz_gecerli_o  = gy_gecerli_q;
  assign geri_yaz_veri_o     = gy_veri_q;
  assign hizasiz_o           = hizasiz_q;

endmodule

// File: tb/tb_bellek_asamasi.sv
// tb/tb_bellek_asamasi.sv - directed self-checking bench for bellek_asamasi
module tb_bellek_asamasi;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] uop;
  logic        uop_gecerli, bel_gecerli, bel_yaz, bel_isaretsiz;
  logic [1:0]  bel_boyut;
  logic [31:0] bel_adres, bel_veri;
  logic        istek_gecerli, istek_hazir, istek_yaz;
  logic [31:0] istek_adres, istek_veri;
  logic [3:0]  istek_maske;
  logic [31:0] l1_veri;
  logic        l1_veri_gecerli, l1_veri_hazir;
  logic        duraklat, gy_gecerli, hizasiz;
  logic [63:0] gy_uop;
  logic [31:0] gy_veri;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bellek_asamasi dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .uop_i               (uop),
    .uop_gecerli_i       (uop_gecerli),
    .bel_gecerli_i       (bel_gecerli),
    .bel_yaz_i           (bel_yaz),
    .bel_boyut_i         (bel_boyut),
    .bel_isaretsiz_i     (bel_isaretsiz),
    .bel_adres_i         (bel_adres),
    .bel_veri_i          (bel_veri),
    .l1v_istek_gecerli_o (istek_gecerli),
    .l1v_istek_hazir_i   (istek_hazir),
    .l1v_istek_adres_o   (istek_adres),
    .l1v_istek_yaz_o     (istek_yaz),
    .l1v_istek_veri_o    (istek_veri),
    .l1v_istek_maske_o   (istek_maske),
    .l1v_veri_i          (l1_veri),
    .l1v_veri_gecerli_i  (l1_veri_gecerli),
    .l1v_veri_hazir_o    (l1_veri_hazir),
    .duraklat_o          (duraklat),
    .geri_yaz_uop_o      (gy_uop),
    .geri_yaz_gecerli_o  (gy_gecerli),
    .geri_yaz_veri_o     (gy_veri),
    .hizasiz_o           (hizasiz)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [63:0] u, input logic mem, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] adr, input logic [31:0] dat);
    uop = u; uop_gecerli = 1'b1; bel_gecerli = mem; bel_yaz = wr; bel_boyut = sz;
    bel_isaretsiz = uns; bel_adres = adr; bel_veri = dat;
  endtask

  task automatic load_half(input logic uns, input logic [31:0] exp);
    present(64'h2222, 1'b1, 1'b0, 2'd1, uns, 32'h2002, 32'h0);
    istek_hazir = 1'b1;
    tick();
    uop_gecerli = 1'b0;
    check_value("ldh_req_mask", istek_maske, 4'b1100);
    tick();
    check_value("ldh_rsp_ready", l1_veri_hazir, 1'b1);
    l1_veri = 32'h8001_0000; l1_veri_gecerli = 1'b1;
    tick();
    l1_veri_gecerli = 1'b0;
    check_value("ldh_valid", gy_gecerli, 1'b1);
    check_value("ldh_data", gy_veri, exp);
  endtask

  initial begin
    rst = 1'b1; uop = '0; uop_gecerli = 1'b0; bel_gecerli = 1'b0; bel_yaz = 1'b0;
    bel_boyut = '0; bel_isaretsiz = 1'b0; bel_adres = '0; bel_veri = '0;
    istek_hazir = 1'b0; l1_veri = '0; l1_veri_gecerli = 1'b0;
    tick(); tick();
    check_value("rst_stall", duraklat, 1'b0);
    check_value("rst_req", istek_gecerli, 1'b0);
    check_value("rst_rsp_ready", l1_veri_hazir, 1'b0);
    check_value("rst_wb_valid", gy_gecerli, 1'b0);
    check_value("rst_wb_uop", gy_uop, 64'h0);
    rst = 1'b0;

    present(64'hABCD, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    uop_gecerli = 1'b0;
    check_value("nm_uop", gy_uop, 64'hABCD);
    check_value("nm_valid", gy_gecerli, 1'b1);
    check_value("nm_no_req", istek_gecerli, 1'b0);
    tick();
    check_value("nm_bubble", gy_gecerli, 1'b0);

    present(64'h5151, 1'b1, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h5A);
    istek_hazir = 1'b1;
    tick();
    uop_gecerli = 1'b0;
    check_value("stb_req", istek_gecerli, 1'b1);
    check_value("stb_addr", istek_adres, 32'h1000);
    check_value("stb_mask", istek_maske, 4'b1000);
    check_value("stb_data", istek_veri, 32'h5A00_0000);
    check_value("stb_write", istek_yaz, 1'b1);
    check_value("stb_busy_bubble", gy_gecerli, 1'b0);
    tick();
    check_value("stb_valid", gy_gecerli, 1'b1);
    check_value("stb_uop", gy_uop, 64'h5151);
    check_value("stb_stall_clear", duraklat, 1'b0);

    present(64'h5252, 1'b1, 1'b1, 2'd1, 1'b0, 32'h1002, 32'hBEEF);
    tick();
    uop_gecerli = 1'b0;
    check_value("sth_mask", istek_maske, 4'b1100);
    check_value("sth_data", istek_veri, 32'hBEEF_0000);
    tick();

    load_half(1'b0, 32'hFFFF_8001);
    load_half(1'b1, 32'h0000_8001);

    present(64'h4444, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0);
    istek_hazir = 1'b0;
    tick();
    present(64'h77, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_value("ldw_wait_req_stall", duraklat, 1'b1);
      check_value("ldw_wait_req_valid", istek_gecerli, 1'b1);
      check_value("ldw_wait_req_bubble", gy_gecerli, 1'b0);
      tick();
    end
    istek_hazir = 1'b1;
    check_value("ldw_req_addr", istek_adres, 32'h4000);
    tick();
    istek_hazir = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_value("ldw_wait_rsp_stall", duraklat, 1'b1);
      check_value("ldw_wait_rsp_ready", l1_veri_hazir, 1'b1);
      tick();
    end
    l1_veri = 32'hDEAD_BEEF; l1_veri_gecerli = 1'b1;
    check_value("ldw_last_stall", duraklat, 1'b1);
    tick();
    l1_veri_gecerli = 1'b0;
    check_value("ldw_valid", gy_gecerli, 1'b1);
    check_value("ldw_uop", gy_uop, 64'h4444);
    check_value("ldw_data", gy_veri, 32'hDEAD_BEEF);
    check_value("ldw_stall_clear", duraklat, 1'b0);
    tick();
    uop_gecerli = 1'b0;
    check_value("next_uop", gy_uop, 64'h77);
    check_value("next_valid", gy_gecerli, 1'b1);
    check_value("next_data_zero", gy_veri, 32'h0);

    present(64'h3333, 1'b1, 1'b0, 2'd2, 1'b0, 32'h3002, 32'h0);
    istek_hazir = 1'b1;
    tick();
    uop_gecerli = 1'b0;
`ifdef BELLEK_HIZALAMA_DENETIMI_EN
    check_value("mis_flag", hizasiz, 1'b1);
    check_value("mis_valid", gy_gecerli, 1'b1);
    check_value("mis_no_req", istek_gecerli, 1'b0);
    check_value("mis_no_stall", duraklat, 1'b0);
`else
    check_value("mis_req", istek_gecerli, 1'b1);
    check_value("mis_addr", istek_adres, 32'h3000);
    check_value("mis_mask", istek_maske, 4'b1111);
    tick();
    l1_veri = 32'h1122_3344; l1_veri_gecerli = 1'b1;
    tick();
    l1_veri_gecerli = 1'b0;
    check_value("mis_data", gy_veri, 32'h1122_3344);
    check_value("mis_flag_low", hizasiz, 1'b0);
`endif
    tick();

    present(64'h5555, 1'b1, 1'b0, 2'd0, 1'b0, 32'h5001, 32'h0);
    istek_hazir = 1'b1;
    tick();
    uop_gecerli = 1'b0;
    tick();
    check_value("rsty_in_yanit", l1_veri_hazir, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("rsty_stall", duraklat, 1'b0);
    check_value("rsty_rsp_ready", l1_veri_hazir, 1'b0);
    check_value("rsty_req", istek_gecerli, 1'b0);
    check_value("rsty_wb_valid", gy_gecerli, 1'b0);
    check_value("rsty_wb_uop", gy_uop, 64'h0);
    l1_veri = 32'h0000_FFFF; l1_veri_gecerli = 1'b1;
    tick();
    l1_veri_gecerli = 1'b0;
    check_value("late_data_ignored", gy_gecerli, 1'b0);
    check_value("late_data_data", gy_veri, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
